// File: rtl/rt_output_arbiter.sv
// Wormhole output-port arbiter: round-robin among NREQ inputs, winner owns the link from head to tail flit.
// Latency: request seen in IDLE -> grant next cycle -> flit accepted that cycle -> out_valid one cycle later.
// Backpressure: owner in_ready = !out_valid | out_ready; a stalled owner keeps the lock, non-owners wait unserved.
module rt_output_arbiter #(
  parameter int n     = 32,
  parameter int NREQ  = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   in_valid,
  input  logic [NREQ-1:0]   in_tail,
  input  logic [NREQ*n-1:0] in_data,
  output logic [NREQ-1:0]   in_ready,
  output logic              out_valid,
  output logic              out_tail,
  output logic [n-1:0]      out_data,
  input  logic              out_ready,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic [CNT_W-1:0]  pkt_count
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] owner_idx;
  logic [PTR_W-1:0] next_ptr;
  logic [NREQ-1:0]  winner_oh;
  logic             found;
  logic             sel_valid;
  logic             sel_tail;
  logic [n-1:0]     sel_data;
  logic             out_free;
  logic             xfer;

  // Round-robin pick: first requester at or after rr_ptr, wrapping around.
  always_comb begin
    winner_oh = '0;
    found     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && in_valid[(int'(rr_ptr) + k) % NREQ]) begin
        winner_oh[(int'(rr_ptr) + k) % NREQ] = 1'b1;
        found = 1'b1;
      end
    end
  end

  // Route the current owner's flit, tail and valid through a one-hot mux.
  always_comb begin
    owner_idx = '0;
    sel_valid = 1'b0;
    sel_tail  = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        owner_idx = PTR_W'(k);
        sel_valid = in_valid[k];
        sel_tail  = in_tail[k];
        sel_data  = in_data[k*n +: n];
      end
    end
  end

  // Handshake: the output register can take a flit when empty or being drained this cycle.
  always_comb begin
    out_free = !out_valid || out_ready;
    xfer     = (state == LOCK) && sel_valid && out_free;
    in_ready = (state == LOCK && out_free) ? grant : '0;
    busy     = (state == LOCK);
    next_ptr = (owner_idx == PTR_W'(NREQ - 1)) ? '0 : owner_idx + 1'b1;
  end

  // Arbitration FSM plus the one-flit output register; rr_ptr moves only on tail acceptance.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      out_valid <= 1'b0;
      out_tail  <= 1'b0;
      out_data  <= '0;
      pkt_count <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_tail  <= sel_tail;
        out_data  <= sel_data;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (|in_valid) begin
            grant <= winner_oh;
            state <= LOCK;
          end
        end
        LOCK: begin
          if (xfer && sel_tail) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= next_ptr;
            pkt_count <= pkt_count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rt_output_arbiter.sv
// Bench for rt_output_arbiter: per-source flit queues drive the inputs, a behavioural model
// of the link (owner, lock, one-flit output slot, rotating priority) is compared every cycle,
// and a packet-integrity scoreboard watches flits leaving the link.
module tb_rt_output_arbiter;
  localparam int N  = 32;
  localparam int NR = 4;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   in_valid;
  logic [NR-1:0]   in_tail;
  logic [NR*N-1:0] in_data;
  logic [NR-1:0]   in_ready;
  logic            out_valid;
  logic            out_tail;
  logic [N-1:0]    out_data;
  logic            out_ready;
  logic [NR-1:0]   grant;
  logic            busy;
  logic [CW-1:0]   pkt_count;

  always #5 clk = ~clk;

  rt_output_arbiter #(.n(N), .NREQ(NR), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_tail(in_tail), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_tail(out_tail), .out_data(out_data), .out_ready(out_ready),
    .grant(grant), .busy(busy), .pkt_count(pkt_count)
  );

  int checks = 0;
  int errors = 0;

  // stimulus state
  logic [32:0] srcq [NR][$];
  bit          holding [NR];
  int          ready_pct = 100;
  int          gap_pct   = 100;
  bit          force_all = 1'b0;
  int          pkt_id    = 0;
  bit          cmp_on    = 1'b0;

  // model state
  bit          m_locked = 0;
  int          m_owner  = 0;
  int          m_rr     = 0;
  logic        m_ov     = 0;
  logic        m_ot     = 0;
  logic [31:0] m_od     = 0;
  int          m_cnt    = 0;
  logic [NR-1:0] m_acc  = 0;

  // scoreboard state
  int cur_src = -1;
  int nxt_idx = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(int s, int p, int i);
    return {s[3:0], p[19:0], i[7:0]};
  endfunction

  task automatic send(int s, int len);
    for (int i = 0; i < len; i++)
      srcq[s].push_back({(i == len - 1) ? 1'b1 : 1'b0, mk(s, pkt_id, i)});
    pkt_id++;
  endtask

  task automatic refresh();
    for (int i = 0; i < NR; i++) begin
      if (!holding[i] && srcq[i].size() > 0 && $urandom_range(99) < gap_pct) holding[i] = 1;
      in_valid[i] = force_all | holding[i];
      if (holding[i]) begin
        in_tail[i]       = srcq[i][0][32];
        in_data[i*N +: N] = srcq[i][0][31:0];
      end else begin
        in_tail[i]       = 1'b0;
        in_data[i*N +: N] = $urandom();
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++)
      if (m_acc[i] && srcq[i].size() > 0) begin
        void'(srcq[i].pop_front());
        holding[i] = 0;
      end
    out_ready = ($urandom_range(99) < ready_pct);
    refresh();
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NR; i++) begin
      srcq[i].delete();
      holding[i] = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_sources();
    refresh();
    tick();
    rst = 1'b1;
    refresh();
  endtask

  function automatic bit link_idle();
    bit e = 1;
    for (int i = 0; i < NR; i++) if (srcq[i].size() != 0) e = 0;
    return e && !m_locked && !m_ov;
  endfunction

  task automatic drain(int budget);
    for (int c = 0; c < budget; c++) begin
      if (link_idle()) break;
      tick();
    end
    check("drain_done", {63'd0, link_idle()}, 64'd1);
  endtask

  // Behavioural model of the link, advanced on each rising edge.
  always @(posedge clk) begin
    m_acc = '0;
    if (!rst) begin
      m_locked = 0; m_owner = 0; m_rr = 0;
      m_ov = 0; m_ot = 0; m_od = 0; m_cnt = 0;
    end else if (m_locked) begin
      if (in_valid[m_owner] && (!m_ov || out_ready)) begin
        m_acc[m_owner] = 1'b1;
        m_ov = 1;
        m_ot = in_tail[m_owner];
        m_od = in_data[m_owner*N +: N];
        if (m_ot) begin
          m_locked = 0;
          m_rr  = (m_owner + 1) % NR;
          m_cnt = (m_cnt + 1) % (1 << CW);
        end
      end else if (out_ready) begin
        m_ov = 0;
      end
    end else begin
      if (out_ready) m_ov = 0;
      for (int k = 0; k < NR; k++) begin
        if (!m_locked && in_valid[(m_rr + k) % NR]) begin
          m_owner  = (m_rr + k) % NR;
          m_locked = 1;
        end
      end
    end
  end

  // Compare DUT against model each cycle, plus packet-integrity scoreboard on delivered flits.
  always @(negedge clk) begin
    logic [NR-1:0] exp_g;
    logic [NR-1:0] exp_r;
    if (cmp_on) begin
      exp_g = m_locked ? NR'(1 << m_owner) : '0;
      exp_r = (m_locked && (!m_ov || out_ready)) ? exp_g : '0;
      check("grant", grant, exp_g);
      check("in_ready", in_ready, exp_r);
      check("busy", busy, m_locked);
      check("out_valid", out_valid, m_ov);
      check("out_tail", out_tail, m_ot);
      check("out_data", out_data, m_od);
      check("pkt_count", pkt_count, m_cnt);
      if (!rst) begin
        cur_src = -1;
      end else if (out_valid && out_ready && out_data[31:28] < NR) begin
        if (cur_src < 0) begin
          check("sb_head_idx", out_data[7:0], 0);
          cur_src = out_data[31:28];
          nxt_idx = 1;
        end else begin
          check("sb_no_interleave", out_data[31:28], cur_src);
          check("sb_flit_order", out_data[7:0], nxt_idx);
          nxt_idx++;
        end
        if (out_tail) cur_src = -1;
      end
    end
  end

  initial begin
    int pid;
    rst = 1'b0;
    force_all = 1'b1;
    out_ready = 1'b1;
    in_valid = '0; in_tail = '0; in_data = '0;
    refresh();

    // reset held with every input requesting
    tick();
    cmp_on = 1'b1;
    tick();
    tick();
    @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_busy", busy, 0);
    tick();
    rst = 1'b1;
    force_all = 1'b0;
    refresh();
    tick();
    tick();

    // single-flit packet on input 2
    srcq[2].push_back({1'b1, 32'hA5A5_0001});
    refresh();
    @(negedge clk);
    check("single_idle_ready", in_ready, 0);
    tick();
    @(negedge clk);
    check("single_grant", grant, 4'b0100);
    check("single_ready", in_ready, 4'b0100);
    tick();
    @(negedge clk);
    check("single_out_valid", out_valid, 1);
    check("single_out_data", out_data, 32'hA5A5_0001);
    check("single_out_tail", out_tail, 1);
    check("single_pkt_count", pkt_count, 1);
    check("model_cnt_single", m_cnt, 1);
    // priority now starts at input 3
    tick();
    send(0, 1);
    send(3, 1);
    refresh();
    tick();
    @(negedge clk);
    check("rr_after_single", grant, 4'b1000);
    drain(200);

    // round-robin across four 2-flit packets
    do_reset();
    for (int i = 0; i < NR; i++) send(i, 2);
    refresh();
    for (int k = 1; k <= 12; k++) begin
      logic [NR-1:0] e;
      tick();
      e = (((k - 1) % 3) < 2) ? NR'(1 << ((k - 1) / 3)) : '0;
      @(negedge clk);
      check($sformatf("rr_grant_k%0d", k), grant, e);
    end
    check("rr_pkt_count", pkt_count, 4);
    check("model_cnt_rr", m_cnt, 4);
    drain(200);

    // lock held under contention
    send(1, 4);
    refresh();
    for (int k = 1; k <= 6; k++) begin
      logic [NR-1:0] e;
      tick();
      if (k == 2) begin
        send(0, 2);
        refresh();
      end
      e = (k <= 4) ? 4'b0010 : ((k == 5) ? 4'b0000 : 4'b0001);
      @(negedge clk);
      check($sformatf("lock_grant_k%0d", k), grant, e);
    end
    drain(200);

    // backpressure mid-packet
    pid = pkt_id;
    send(3, 4);
    refresh();
    tick();
    tick();
    ready_pct = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_out_data", out_data, mk(3, pid, 0));
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      tick();
    end
    ready_pct = 100;
    out_ready = 1'b1;
    drain(200);
    check("bp_pkt_count", pkt_count, 7);

    // reset in the middle of a 5-flit packet while rr_ptr points at input 2
    send(1, 1);
    refresh();
    drain(200);
    send(2, 5);
    refresh();
    tick();
    tick();
    rst = 1'b0;
    clear_sources();
    refresh();
    tick();
    rst = 1'b1;
    send(0, 1);
    send(3, 1);
    refresh();
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_grant", grant, 0);
    tick();
    @(negedge clk);
    check("mid_rst_next_grant", grant, 4'b0001);
    drain(200);

    // randomized traffic with backpressure and source gaps
    ready_pct = 70;
    gap_pct   = 60;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(9) == 0) send($urandom_range(NR - 1), $urandom_range(1, 4));
      tick();
    end
    ready_pct = 100;
    gap_pct   = 100;
    drain(3000);

    // counter wrap: 17 packets on a 4-bit counter
    do_reset();
    for (int p = 0; p < 17; p++) send(p % NR, 1);
    refresh();
    drain(500);
    @(negedge clk);
    check("wrap_pkt_count", pkt_count, 1);
    check("model_cnt_wrap", m_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
